// File: rtl/serial_clk_pkg.sv
// Shared types and width helpers for the serial clock scheduler and its arbiter.
package serial_clk_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, FINISH} state_e;

  localparam int DEF_NREQ  = 2;
  localparam int DEF_LEN_W = 8;

  // Pointer width that stays legal even for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter
  import serial_clk_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [PTR_W-1:0] idx_o
);

  logic found;
  int   cand;

  // NOTE: every variable is given a default first so no path can infer a latch.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = (int'(ptr_i) + off) % NREQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/serial_clk_scheduler.sv
// Shares one clock divider among NREQ requesters: arbitrates, clears the divider,
// runs it for exactly len bit periods with shift/sample strobes, then parks it low.
module serial_clk_scheduler
  import serial_clk_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*LEN_W-1:0] req_len_i,
  input  logic                  abort_i,
  output logic [NREQ-1:0]       grant_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic [LEN_W-1:0]      bit_idx_o,
  output logic                  shift_stb_o,
  output logic                  sample_stb_o,
  output logic                  div_clear_o,
  output logic                  enable_clk_o,
  input  logic                  div_rising_i,
  input  logic                  div_falling_i,
  input  logic                  div_mid_high_i,
  input  logic                  div_mid_low_i
);

  localparam int PTR_W = ptr_width(NREQ);
  localparam int CW    = LEN_W + 1;  // one spare bit so len = 2^LEN_W-1 cannot wrap

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     rises_q, rises_d;
  logic [CW-1:0]     falls_q, falls_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [LEN_W-1:0]  bit_idx_q, bit_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              shift_q, shift_d;
  logic              sample_q, sample_d;
  logic              clear_q, clear_d;
  logic              enable_q, enable_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]  arb_idx;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    rises_d   = rises_q;
    falls_d   = falls_q;
    grant_d   = grant_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    shift_d   = 1'b0;
    sample_d  = 1'b0;
    clear_d   = 1'b0;
    enable_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d   = CLEAR;
          grant_d   = arb_gnt;
          len_d     = {1'b0, req_len_i[int'(arb_idx)*LEN_W +: LEN_W]};
          ptr_d     = (int'(arb_idx) == NREQ-1) ? '0 : arb_idx + PTR_W'(1);
          rises_d   = '0;
          falls_d   = '0;
          bit_idx_d = '0;
          clear_d   = 1'b1;
        end
      end
      CLEAR: begin
        if (abort_i) begin
          state_d   = FINISH;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          clear_d   = 1'b1;
        end else if (len_q != '0) begin
          state_d  = RUN;
          enable_d = 1'b1;
        end else begin
          state_d = FINISH;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d   = FINISH;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          clear_d   = 1'b1;
        end else begin
          enable_d = 1'b1;
          shift_d  = div_mid_low_i && (rises_q < len_q);
          sample_d = div_mid_high_i;
          if (div_rising_i) rises_d = rises_q + CW'(1);
          if (div_falling_i) begin
            falls_d = falls_q + CW'(1);
            if ((CW'(bit_idx_q) + CW'(1)) < len_q) bit_idx_d = bit_idx_q + LEN_W'(1);
            if ((falls_q + CW'(1)) == len_q) begin
              state_d  = FINISH;
              enable_d = 1'b0;
              done_d   = 1'b1;
            end
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: registers use <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      len_q     <= '0;
      rises_q   <= '0;
      falls_q   <= '0;
      grant_q   <= '0;
      bit_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      shift_q   <= 1'b0;
      sample_q  <= 1'b0;
      clear_q   <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      rises_q   <= rises_d;
      falls_q   <= falls_d;
      grant_q   <= grant_d;
      bit_idx_q <= bit_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      clear_q   <= clear_d;
      enable_q  <= enable_d;
    end
  end

  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;
  assign bit_idx_o    = bit_idx_q;
  assign shift_stb_o  = shift_q;
  assign sample_stb_o = sample_q;
  assign div_clear_o  = clear_q;
  assign enable_clk_o = enable_q;

endmodule

// File: tb/tb_serial_clk_scheduler.sv
// Bench for serial_clk_scheduler driving a 10-bit divider model (1024-cycle bit period).
module tb_serial_clk_scheduler;

  localparam int NREQ  = 2;
  localparam int LEN_W = 8;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_i;
  logic [NREQ*LEN_W-1:0] req_len_i;
  logic                  abort_i;
  logic [NREQ-1:0]       grant_o;
  logic                  busy_o, done_o, aborted_o;
  logic [LEN_W-1:0]      bit_idx_o;
  logic                  shift_stb_o, sample_stb_o, div_clear_o, enable_clk_o;

  // divider model: counter runs while enabled, new_clk is its MSB
  logic [9:0] dcnt, dnxt;
  logic       new_clk, d_rise, d_fall, d_mh, d_ml;

  assign dnxt = dcnt + 10'd1;

  always @(posedge clk or posedge rst) begin
    if (rst || div_clear_o) begin
      dcnt <= '0; new_clk <= 1'b0;
      d_rise <= 1'b0; d_fall <= 1'b0; d_mh <= 1'b0; d_ml <= 1'b0;
    end else if (enable_clk_o) begin
      dcnt    <= dnxt;
      new_clk <= dnxt[9];
      d_rise  <= (dnxt == 10'd512);
      d_fall  <= (dnxt == 10'd0);
      d_mh    <= (dnxt == 10'd768);
      d_ml    <= (dnxt == 10'd256);
    end else begin
      d_rise <= 1'b0; d_fall <= 1'b0; d_mh <= 1'b0; d_ml <= 1'b0;
    end
  end

  serial_clk_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req_i),
    .req_len_i      (req_len_i),
    .abort_i        (abort_i),
    .grant_o        (grant_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .aborted_o      (aborted_o),
    .bit_idx_o      (bit_idx_o),
    .shift_stb_o    (shift_stb_o),
    .sample_stb_o   (sample_stb_o),
    .div_clear_o    (div_clear_o),
    .enable_clk_o   (enable_clk_o),
    .div_rising_i   (d_rise),
    .div_falling_i  (d_fall),
    .div_mid_high_i (d_mh),
    .div_mid_low_i  (d_ml)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  int rise_total = 0, shift_total = 0, sample_total = 0, en_total = 0;
  int last_fall_cyc = -10;
  int n_checks = 0, n_errors = 0;
  int m_ptr = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (d_rise)       rise_total++;
    if (shift_stb_o)  shift_total++;
    if (sample_stb_o) sample_total++;
    if (enable_clk_o) en_total++;
    if (d_fall)       last_fall_cyc = cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference arbitration: first requester at or after the pointer, wrapping
  function automatic int model_pick(input logic [NREQ-1:0] rq, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  // drop: 0 keep req, 1 drop req once granted, 2 drop req after first divider rising edge
  task automatic do_xfer(input string tag, input logic [1:0] rq, input logic [7:0] l0,
                         input logic [7:0] l1, input int drop, input logic [1:0] exp_g,
                         input int exp_bits);
    int  r0, s0, sm0, e0, g_cyc, d_cyc, budget;
    bit  to, held;
    r0 = rise_total; s0 = shift_total; sm0 = sample_total; e0 = en_total;
    req_i = rq; req_len_i = {l1, l0};
    to = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (grant_o != '0) begin to = 1'b0; break; end
    end
    check({tag, "_grant_timeout"}, 32'(to), 0);
    if (to) begin req_i = '0; return; end
    g_cyc = cyc;
    check({tag, "_grant"}, 32'(grant_o), 32'(exp_g));
    if (drop == 1) req_i = '0;
    held = 1'b1; to = 1'b1;
    budget = 1100 * exp_bits + 50;
    for (int k = 0; k < budget; k++) begin
      if (done_o) begin to = 1'b0; break; end
      if (grant_o !== exp_g) held = 1'b0;
      if (drop == 2 && (rise_total - r0) >= 1) req_i = '0;
      @(negedge clk);
    end
    d_cyc = cyc;
    check({tag, "_done_timeout"}, 32'(to), 0);
    check({tag, "_grant_held"}, 32'(held && (grant_o == exp_g)), 1);
    check({tag, "_aborted"}, 32'(aborted_o), 0);
    check({tag, "_rises"}, 32'(rise_total - r0), 32'(exp_bits));
    check({tag, "_shifts"}, 32'(shift_total - s0), 32'(exp_bits));
    check({tag, "_samples"}, 32'(sample_total - sm0), 32'(exp_bits));
    check({tag, "_bit_idx"}, 32'(bit_idx_o), 32'((exp_bits > 0) ? exp_bits - 1 : 0));
    check({tag, "_new_clk_low"}, 32'(new_clk), 0);
    if (exp_bits == 0) begin
      check({tag, "_no_enable"}, 32'(en_total - e0), 0);
      check({tag, "_len0_latency"}, 32'(d_cyc - g_cyc), 1);
    end else begin
      check({tag, "_done_after_fall"}, 32'(d_cyc - last_fall_cyc), 1);
    end
    @(negedge clk);
    check({tag, "_idle_gap"}, 32'({grant_o, busy_o, done_o}), 0);
    m_ptr = (exp_g[NREQ-1]) ? 0 : 1;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] l0;
    logic [7:0] l1;
    int         drop;
    logic [1:0] exp_g;
    int         exp_bits;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  r0, s0;
    bit  to;
    vecs[0] = '{2'b01, 8'd3, 8'd0, 1, 2'b01, 3};  // basic 3-bit transfer
    vecs[1] = '{2'b10, 8'd0, 8'd0, 1, 2'b10, 0};  // zero-length transfer
    vecs[2] = '{2'b11, 8'd1, 8'd1, 0, 2'b01, 1};  // held requests alternate
    vecs[3] = '{2'b11, 8'd1, 8'd1, 0, 2'b10, 1};
    vecs[4] = '{2'b11, 8'd1, 8'd1, 0, 2'b01, 1};
    vecs[5] = '{2'b11, 8'd1, 8'd1, 0, 2'b10, 1};
    vecs[6] = '{2'b01, 8'd2, 8'd5, 2, 2'b01, 2};  // req drops mid-run
    vecs[7] = '{2'b11, 8'd2, 8'd1, 1, 2'b10, 1};

    rst = 1'b0; req_i = '0; req_len_i = '0; abort_i = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_outputs", 32'({grant_o, busy_o, done_o, aborted_o, bit_idx_o, shift_stb_o,
                                sample_stb_o, div_clear_o, enable_clk_o}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;

    for (int v = 0; v < 8; v++)
      do_xfer($sformatf("vec%0d", v), vecs[v].req, vecs[v].l0, vecs[v].l1,
              vecs[v].drop, vecs[v].exp_g, vecs[v].exp_bits);

    // abort 100 cycles after the second rising edge of an 8-bit transfer
    req_i = 2'b01; req_len_i = {8'd0, 8'd8};
    to = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (grant_o != '0) begin to = 1'b0; break; end
    end
    check("abort_grant", 32'(grant_o), 32'(2'b01));
    req_i = '0;
    r0 = rise_total; s0 = shift_total;
    to = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rise_total - r0 >= 2) begin to = 1'b0; break; end
    end
    check("abort_wait_rise_timeout", 32'(to), 0);
    repeat (100) @(negedge clk);
    check("abort_pre_enable", 32'(enable_clk_o), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_enable_off", 32'(enable_clk_o), 0);
    check("abort_div_clear", 32'(div_clear_o), 1);
    check("abort_done", 32'({done_o, aborted_o}), 32'(2'b11));
    check("abort_bit_idx_lt8", 32'(bit_idx_o < 8'd8), 1);
    @(negedge clk);
    check("abort_idle", 32'({grant_o, busy_o, done_o, aborted_o}), 0);
    repeat (1100) @(negedge clk);
    check("abort_no_more_rises", 32'(rise_total - r0), 2);
    check("abort_shifts", 32'(shift_total - s0), 2);
    m_ptr = 1;

    // async reset in the middle of a run restores the pointer to requester 0
    req_i = 2'b01; req_len_i = {8'd0, 8'd4};
    r0 = rise_total;
    to = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (rise_total - r0 >= 1) begin to = 1'b0; break; end
    end
    check("rst_wait_rise_timeout", 32'(to), 0);
    check("rst_pre_running", 32'({busy_o, enable_clk_o, grant_o}), 32'(4'b1101));
    #2 rst = 1'b1; req_i = '0;
    #1;
    check("rst_async_outputs", 32'({grant_o, busy_o, done_o, aborted_o, bit_idx_o, shift_stb_o,
                                    sample_stb_o, div_clear_o, enable_clk_o}), 0);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    do_xfer("rst_after", 2'b11, 8'd1, 8'd1, 1, 2'b01, 1);

    // randomized transfers against the arbitration model
    for (int t = 0; t < 8; t++) begin
      logic [1:0] rq;
      logic [7:0] l0, l1;
      int         w, dr;
      rq = 2'($urandom_range(1, 3));
      l0 = 8'($urandom_range(0, 2));
      l1 = 8'($urandom_range(0, 2));
      dr = int'($urandom_range(0, 2));
      w  = model_pick(rq, m_ptr);
      do_xfer($sformatf("rand%0d", t), rq, l0, l1, dr, 2'(1 << w), (w == 1) ? int'(l1) : int'(l0));
    end
    req_i = '0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
